// File: rtl/id_ex_pipe_stage.sv
// ID/EX valid/ready stage: registered output slot backed by an in-order skid FIFO.
// Optional stall/flush statistics counters are built when ID_EX_STAGE_STATS_EN is defined.
module id_ex_pipe_stage #(
  parameter int              WIDTH      = 32,
  parameter int              SKID_DEPTH = 2,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
  parameter int              OCC_W      = $clog2(SKID_DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
`ifdef ID_EX_STAGE_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SKID_DEPTH);

  logic [WIDTH-1:0] skid_mem [SKID_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
  logic [CNT_W-1:0] skid_cnt, skid_cnt_d;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_d;
  logic [OCC_W-1:0] occ_d;

  logic skid_full, skid_empty;
  logic accept, consume, slot_free;
  logic pop, push, bypass;

  // Non-power-of-two depths need an explicit wrap back to zero.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    skid_full  = (skid_cnt == FULL_CNT);
    skid_empty = (skid_cnt == '0);
    in_ready   = !skid_full;
    accept     = in_valid & in_ready;
    consume    = out_valid & out_ready;
    slot_free  = !out_valid | consume;
    pop        = slot_free & !skid_empty;
    bypass     = slot_free & skid_empty & accept;
    push       = accept & !bypass;
  end

  always_comb begin
    out_valid_d = out_valid;
    out_data_d  = out_data;
    skid_cnt_d  = skid_cnt;
    rd_ptr_d    = rd_ptr;
    wr_ptr_d    = wr_ptr;

    if (slot_free) begin
      if (pop) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_mem[rd_ptr];
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = BUBBLE_VAL;
      end
    end

    if (push && !pop) skid_cnt_d = skid_cnt + CNT_W'(1);
    else if (pop && !push) skid_cnt_d = skid_cnt - CNT_W'(1);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr);
    if (push) wr_ptr_d = ptr_inc(wr_ptr);

    // Squash overrides every load, push and pop decided above.
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = BUBBLE_VAL;
      skid_cnt_d  = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
    end

    occ_d = OCC_W'(skid_cnt_d) + OCC_W'(out_valid_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE_VAL;
      skid_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      skid_cnt  <= skid_cnt_d;
      rd_ptr    <= rd_ptr_d;
      wr_ptr    <= wr_ptr_d;
      occupancy <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) skid_mem[wr_ptr] <= in_data;
  end

`ifdef ID_EX_STAGE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: queue-level model checked every cycle plus directed literal checks.
// Define ID_EX_STAGE_STATS_EN to also exercise the stall/flush counters.
module tb_id_ex_pipe_stage;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] occupancy;
`ifdef ID_EX_STAGE_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] mq[$];
  logic [7:0] dut_emit[$];
  logic [7:0] exp_emit[$];

  id_ex_pipe_stage #(
    .WIDTH(8),
    .SKID_DEPTH(DEPTH),
    .BUBBLE_VAL(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy)
`ifdef ID_EX_STAGE_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // The stage behaves as an ordered store of up to DEPTH+1 entries; the head is the output.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      bit acc, con;
      cyc++;
      acc = in_valid && (mq.size() <= DEPTH);
      con = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("model_out_data", {24'd0, out_data}, {24'd0, (mq.size() > 0) ? mq[0] : 8'h00});
    chk("model_occupancy", {30'd0, occupancy}, 32'(mq.size()));
    chk("model_in_ready", {31'd0, in_ready}, {31'd0, mq.size() <= DEPTH});
    if (rst && out_valid && out_ready) dut_emit.push_back(out_data);
  end

  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [7:0] d,
                         input logic [1:0] occ, input logic rdy);
    chk({nm, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({nm, "_data"}, {24'd0, out_data}, {24'd0, d});
    chk({nm, "_occ"}, {30'd0, occupancy}, {30'd0, occ});
    chk({nm, "_ready"}, {31'd0, in_ready}, {31'd0, rdy});
  endtask

  task automatic chk_emit(input string nm);
    chk({nm, "_count"}, 32'(dut_emit.size()), 32'(exp_emit.size()));
    for (int i = 0; i < exp_emit.size(); i++)
      chk($sformatf("%s_item%0d", nm, i),
          {24'd0, (i < dut_emit.size()) ? dut_emit[i] : 8'hxx}, {24'd0, exp_emit[i]});
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Basic stream
    dut_emit.delete();
    step(1'b1, 8'h11, 1'b1, 1'b0); chk_out("stream0", 1'b1, 8'h11, 2'd1, 1'b1);
    step(1'b1, 8'h22, 1'b1, 1'b0); chk_out("stream1", 1'b1, 8'h22, 2'd1, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b0); chk_out("stream2", 1'b1, 8'h33, 2'd1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0); chk_out("stream_end", 1'b0, 8'h00, 2'd0, 1'b1);
    exp_emit = '{8'h11, 8'h22, 8'h33};
    chk_emit("stream_emit");

    // Back-pressure fills output plus both skid entries, then drains in order
    dut_emit.delete();
    step(1'b1, 8'h11, 1'b0, 1'b0); chk_out("bp0", 1'b1, 8'h11, 2'd1, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b0); chk_out("bp1", 1'b1, 8'h11, 2'd2, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b0); chk_out("bp2", 1'b1, 8'h11, 2'd3, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0); chk_out("bp_full", 1'b1, 8'h11, 2'd3, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b0); chk_out("bp_rel0", 1'b1, 8'h22, 2'd2, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b0); chk_out("bp_rel1", 1'b1, 8'h33, 2'd2, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0); chk_out("bp_rel2", 1'b1, 8'h44, 2'd1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0); chk_out("bp_rel3", 1'b0, 8'h00, 2'd0, 1'b1);
    exp_emit = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk_emit("bp_emit");

    // Flush under load, then flush while an accept would have bypassed
    dut_emit.delete();
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0); chk_out("fl_load", 1'b1, 8'hA1, 2'd3, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1); chk_out("fl_full", 1'b0, 8'h00, 2'd0, 1'b1);
    step(1'b1, 8'h56, 1'b0, 1'b1); chk_out("fl_accept", 1'b0, 8'h00, 2'd0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0); chk_out("fl_after", 1'b0, 8'h00, 2'd0, 1'b1);
    exp_emit.delete();
    chk_emit("fl_emit");

    // Flush coinciding with a consume: the consumed entry still counts as delivered
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b1, 1'b1); chk_out("fl_consume", 1'b0, 8'h00, 2'd0, 1'b1);
    exp_emit = '{8'hD1};
    chk_emit("fl_consume_emit");

    // Simultaneous push and pop at steady occupancy 2
    dut_emit.delete();
    step(1'b1, 8'h60, 1'b0, 1'b0);
    step(1'b1, 8'h61, 1'b0, 1'b0); chk_out("pp_setup", 1'b1, 8'h60, 2'd2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h62 + 8'(i), 1'b1, 1'b0);
      chk($sformatf("pp_occ%0d", i), {30'd0, occupancy}, 32'd2);
      chk($sformatf("pp_data%0d", i), {24'd0, out_data}, {24'd0, 8'h61 + 8'(i)});
    end
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    exp_emit.delete();
    for (int i = 0; i < 12; i++) exp_emit.push_back(8'h60 + 8'(i));
    chk_emit("pp_emit");

    // Asynchronous reset between edges with the stage full
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hB3, 1'b0, 1'b0); chk_out("ar_load", 1'b1, 8'hB1, 2'd3, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1 chk_out("ar_async", 1'b0, 8'h00, 2'd0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 8'hC1, 1'b1, 1'b0); chk_out("ar_first", 1'b1, 8'hC1, 2'd1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0); chk_out("ar_drain", 1'b0, 8'h00, 2'd0, 1'b1);

`ifdef ID_EX_STAGE_STATS_EN
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("stats_reset_stall", {16'd0, stall_cnt}, 32'd0);
    chk("stats_reset_flush", {16'd0, flush_cnt}, 32'd0);
    rst = 1'b1;
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stats_stall5", {16'd0, stall_cnt}, 32'd5);
    chk("stats_flush2", {16'd0, flush_cnt}, 32'd2);
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    repeat (70000) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stats_stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("stats_flush_hold", {16'd0, flush_cnt}, 32'd2);
`endif

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
